// File: rtl/huffman_seq_ctrl.sv
// huffman_seq_ctrl
// Runs one Huffman code-generation pass: tree build, then code-stack generation,
// then captures the code table and serves table lookups to two encoder channels.
module huffman_seq_ctrl #(
   parameter int NUM_SYM       = 10,
   parameter int CODE_WAIT     = 64,
   parameter int BUILD_TIMEOUT = 255
) (
   input  logic                   Clk_in,
   input  logic                   n_Rst,
   input  logic                   Start,
   output logic                   Busy,
   output logic                   Ready,
   output logic                   Err,
   output logic                   Build_start,
   input  logic                   Build_done,
   output logic                   Code_start,
   input  logic [NUM_SYM*13-1:0]  Code_bus,
   input  logic                   Req0,
   input  logic                   Req1,
   input  logic [3:0]             Sym0,
   input  logic [3:0]             Sym1,
   output logic                   Gnt0,
   output logic                   Gnt1,
   output logic                   Rd_valid,
   output logic                   Rd_id,
   output logic [12:0]            Rd_code,
   output logic                   Rd_err
);

   localparam int BW = $clog2(BUILD_TIMEOUT);
   localparam int WW = $clog2(CODE_WAIT);
   localparam logic [BW-1:0] BUILD_MAX = BW'(BUILD_TIMEOUT);
   localparam logic [WW-1:0] WAIT_LAST = WW'(CODE_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BUILD,
      S_CODE,
      S_WAIT,
      S_CAPTURE,
      S_READY,
      S_ERR
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [BW-1:0]   build_cnt;
   logic [WW-1:0]   wait_cnt;
   logic            code_cnt;
   logic            rr;
   logic [12:0]     code_table [NUM_SYM];
   logic [3:0]      sel_sym;
   logic            sel_bad;

   // State register
   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and phase outputs
   always_comb begin
      next_state  = state;
      Busy        = 1'b0;
      Ready       = 1'b0;
      Err         = 1'b0;
      Build_start = 1'b0;
      Code_start  = 1'b0;
      case (state)
         S_IDLE: begin
            if (Start) next_state = S_BUILD;
         end
         S_BUILD: begin
            Busy = 1'b1;
            // counter is zero only in the first BUILD cycle
            Build_start = (build_cnt == '0);
            if (Build_done) begin
               next_state = S_CODE;
            end else if (build_cnt == BUILD_MAX) begin
               next_state = S_ERR;
            end
         end
         S_CODE: begin
            Busy       = 1'b1;
            Code_start = 1'b1;
            if (code_cnt) next_state = S_WAIT;
         end
         S_WAIT: begin
            Busy = 1'b1;
            if (wait_cnt == WAIT_LAST) next_state = S_CAPTURE;
         end
         S_CAPTURE: begin
            Busy       = 1'b1;
            next_state = S_READY;
         end
         S_READY: begin
            Ready = 1'b1;
            if (Start) next_state = S_BUILD;
         end
         S_ERR: begin
            Err = 1'b1;
            if (Start) next_state = S_BUILD;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Phase counters: build timeout, code-start width, code-stack wait; all saturate
   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst) begin
         build_cnt <= '0;
         wait_cnt  <= '0;
         code_cnt  <= 1'b0;
      end else begin
         if (state == S_BUILD) begin
            if (build_cnt != BUILD_MAX) build_cnt <= build_cnt + 1'b1;
         end else begin
            build_cnt <= '0;
         end
         if (state == S_WAIT) begin
            if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         code_cnt <= (state == S_CODE);
      end
   end

   // Code table capture, one cycle in CAPTURE
   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst) begin
         for (int unsigned i = 0; i < NUM_SYM; i++) begin
            code_table[i] <= '0;
         end
      end else if (state == S_CAPTURE) begin
         for (int unsigned i = 0; i < NUM_SYM; i++) begin
            code_table[i] <= Code_bus[i*13 +: 13];
         end
      end
   end

   // Round-robin grant, only while the table is ready
   always_comb begin
      Gnt0 = 1'b0;
      Gnt1 = 1'b0;
      if (state == S_READY) begin
         if (Req0 && Req1) begin
            if (rr) Gnt1 = 1'b1;
            else    Gnt0 = 1'b1;
         end else if (Req0) begin
            Gnt0 = 1'b1;
         end else if (Req1) begin
            Gnt1 = 1'b1;
         end
      end
   end

   // Lookup symbol of the granted channel and its range check
   always_comb begin
      sel_sym = Gnt1 ? Sym1 : Sym0;
      sel_bad = (32'(sel_sym) >= NUM_SYM);
   end

   // Round-robin pointer: after any grant, favour the other channel
   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst) begin
         rr <= 1'b0;
      end else if (Gnt0) begin
         rr <= 1'b1;
      end else if (Gnt1) begin
         rr <= 1'b0;
      end
   end

   // Registered lookup result, one cycle after the grant
   always_ff @(posedge Clk_in or negedge n_Rst) begin
      if (!n_Rst) begin
         Rd_valid <= 1'b0;
         Rd_id    <= 1'b0;
         Rd_code  <= '0;
         Rd_err   <= 1'b0;
      end else if (Gnt0 || Gnt1) begin
         Rd_valid <= 1'b1;
         Rd_id    <= Gnt1;
         Rd_code  <= sel_bad ? '0 : code_table[sel_sym];
         Rd_err   <= sel_bad;
      end else begin
         Rd_valid <= 1'b0;
         Rd_id    <= 1'b0;
         Rd_code  <= '0;
         Rd_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_huffman_seq_ctrl.sv
// tb_huffman_seq_ctrl
// Directed vectors for huffman_seq_ctrl: pass sequencing, capture timing,
// arbitration, bad symbols, build timeout, restart and mid-pass reset.
module tb_huffman_seq_ctrl;

   localparam int NUM_SYM   = 10;
   localparam int CODE_WAIT = 64;

   logic                  Clk_in = 1'b0;
   logic                  n_Rst = 1'b0;
   logic                  Start = 1'b0;
   logic                  Build_done = 1'b0;
   logic [NUM_SYM*13-1:0] Code_bus = '0;
   logic                  Req0 = 1'b0;
   logic                  Req1 = 1'b0;
   logic [3:0]            Sym0 = '0;
   logic [3:0]            Sym1 = '0;
   logic                  Busy, Ready, Err, Build_start, Code_start;
   logic                  Gnt0, Gnt1, Rd_valid, Rd_id, Rd_err;
   logic [12:0]           Rd_code;

   huffman_seq_ctrl #(
      .NUM_SYM(10),
      .CODE_WAIT(64),
      .BUILD_TIMEOUT(255)
   ) dut (
      .Clk_in(Clk_in), .n_Rst(n_Rst), .Start(Start), .Busy(Busy), .Ready(Ready),
      .Err(Err), .Build_start(Build_start), .Build_done(Build_done),
      .Code_start(Code_start), .Code_bus(Code_bus), .Req0(Req0), .Req1(Req1),
      .Sym0(Sym0), .Sym1(Sym1), .Gnt0(Gnt0), .Gnt1(Gnt1), .Rd_valid(Rd_valid),
      .Rd_id(Rd_id), .Rd_code(Rd_code), .Rd_err(Rd_err)
   );

   always #5 Clk_in = ~Clk_in;

   typedef struct {
      logic        r0;
      logic [3:0]  s0;
      logic        r1;
      logic [3:0]  s1;
      logic        g0;
      logic        g1;
      logic        v;
      logic        id;
      logic [12:0] code;
      logic        err;
   } vec_t;

   vec_t        vecs [21];
   logic [12:0] tab_a [NUM_SYM];
   logic [12:0] tab_b [NUM_SYM];
   logic [12:0] cur_tab [NUM_SYM];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic r0, input logic [3:0] s0, input logic r1,
                                input logic [3:0] s1, input logic g0, input logic g1,
                                input logic v, input logic id, input logic [12:0] code,
                                input logic err);
      vec_t x;
      x.r0 = r0; x.s0 = s0; x.r1 = r1; x.s1 = s1; x.g0 = g0; x.g1 = g1;
      x.v = v; x.id = id; x.code = code; x.err = err;
      return x;
   endfunction

   // Each vector: inputs for one READY cycle, the grant expected in that cycle,
   // and the result expected from the previous cycle's grant.
   task automatic apply_vecs(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         @(posedge Clk_in); #1;
         Req0 = vecs[i].r0; Sym0 = vecs[i].s0;
         Req1 = vecs[i].r1; Sym1 = vecs[i].s1;
         @(negedge Clk_in);
         chk($sformatf("vec%0d_gnt0", i), Gnt0, vecs[i].g0);
         chk($sformatf("vec%0d_gnt1", i), Gnt1, vecs[i].g1);
         chk($sformatf("vec%0d_rd_valid", i), Rd_valid, vecs[i].v);
         if (vecs[i].v) begin
            chk($sformatf("vec%0d_rd_id", i), Rd_id, vecs[i].id);
            chk($sformatf("vec%0d_rd_code", i), Rd_code, vecs[i].code);
            chk($sformatf("vec%0d_rd_err", i), Rd_err, vecs[i].err);
         end
      end
      @(posedge Clk_in); #1;
      Req0 = 1'b0; Req1 = 1'b0;
   endtask

   // Full pass: Start, Build_done 5 cycles after Build_start, 2-cycle Code_start,
   // capture exactly CODE_WAIT cycles after Code_start falls (the valid table is on
   // the bus only in that cycle), Ready the cycle after.
   task automatic do_pass(input bit with_grant, input logic [12:0] old_code);
      logic [NUM_SYM*13-1:0] good;
      logic [NUM_SYM*13-1:0] junk;
      for (int i = 0; i < NUM_SYM; i++) good[i*13 +: 13] = cur_tab[i];
      junk = ~good;
      Code_bus = junk;
      @(posedge Clk_in); #1;
      Start = 1'b1;
      if (with_grant) begin Req0 = 1'b1; Sym0 = 4'd5; end
      @(negedge Clk_in);
      if (with_grant) chk("t5_gnt_with_start", Gnt0, 1);
      @(posedge Clk_in); #1;
      Start = 1'b0;
      if (with_grant) begin Req1 = 1'b1; Sym1 = 4'd1; end
      @(negedge Clk_in);
      chk("pass_build_start", Build_start, 1);
      chk("pass_busy", Busy, 1);
      chk("pass_ready_low", Ready, 0);
      chk("pass_err_clear", Err, 0);
      if (with_grant) begin
         chk("t5_rd_valid", Rd_valid, 1);
         chk("t5_rd_id", Rd_id, 0);
         chk("t5_rd_code_old", Rd_code, old_code);
         chk("t5_no_gnt0", Gnt0, 0);
         chk("t5_no_gnt1", Gnt1, 0);
      end
      for (int k = 1; k <= 5; k++) begin
         @(posedge Clk_in); #1;
         Req0 = 1'b0; Req1 = 1'b0;
         if (k == 5) Build_done = 1'b1;
         @(negedge Clk_in);
         if (k == 1) begin
            chk("pass_build_start_once", Build_start, 0);
            chk("pass_rd_valid_idle", Rd_valid, 0);
         end
         if (k == 5) chk("pass_code_start_early", Code_start, 0);
      end
      @(posedge Clk_in); #1;
      Build_done = 1'b0;
      @(negedge Clk_in);
      chk("pass_code_start_c1", Code_start, 1);
      @(posedge Clk_in); #1;
      @(negedge Clk_in);
      chk("pass_code_start_c2", Code_start, 1);
      for (int k = 0; k <= CODE_WAIT + 1; k++) begin
         @(posedge Clk_in); #1;
         Code_bus = (k == CODE_WAIT) ? good : junk;
         @(negedge Clk_in);
         if (k == 0) begin
            chk("pass_code_start_fall", Code_start, 0);
            chk("pass_busy_wait", Busy, 1);
         end
         if (k == CODE_WAIT) chk("pass_ready_early", Ready, 0);
         if (k == CODE_WAIT + 1) begin
            chk("pass_ready", Ready, 1);
            chk("pass_busy_done", Busy, 0);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tab_a = '{13'h0201, 13'h0403, 13'h0607, 13'h0C05, 13'h0A11,
                13'h0E22, 13'h1033, 13'h1244, 13'h1455, 13'h1FFF};
      tab_b = '{13'h0111, 13'h0322, 13'h0533, 13'h0744, 13'h0955,
                13'h0B66, 13'h0D77, 13'h0F88, 13'h1199, 13'h13AA};
      vecs[0]  = mkv(1, 3,  0, 0,  1, 0, 0, 0, 13'h0, 0);
      vecs[1]  = mkv(0, 0,  0, 0,  0, 0, 1, 0, tab_a[3], 0);
      vecs[2]  = mkv(0, 0,  1, 12, 0, 1, 0, 0, 13'h0, 0);
      vecs[3]  = mkv(0, 0,  0, 0,  0, 0, 1, 1, 13'h0, 1);
      vecs[4]  = mkv(1, 0,  1, 9,  1, 0, 0, 0, 13'h0, 0);
      vecs[5]  = mkv(1, 0,  1, 9,  0, 1, 1, 0, tab_a[0], 0);
      vecs[6]  = mkv(1, 0,  1, 9,  1, 0, 1, 1, tab_a[9], 0);
      vecs[7]  = mkv(1, 0,  1, 9,  0, 1, 1, 0, tab_a[0], 0);
      vecs[8]  = mkv(0, 0,  0, 0,  0, 0, 1, 1, tab_a[9], 0);
      vecs[9]  = mkv(0, 0,  0, 0,  0, 0, 0, 0, 13'h0, 0);
      vecs[10] = mkv(0, 0,  1, 15, 0, 1, 0, 0, 13'h0, 0);
      vecs[11] = mkv(1, 10, 0, 0,  1, 0, 1, 1, 13'h0, 1);
      vecs[12] = mkv(0, 0,  1, 7,  0, 1, 1, 0, 13'h0, 1);
      vecs[13] = mkv(0, 0,  0, 0,  0, 0, 1, 1, tab_a[7], 0);
      vecs[14] = mkv(0, 0,  0, 0,  0, 0, 0, 0, 13'h0, 0);
      vecs[15] = mkv(1, 5,  0, 0,  1, 0, 0, 0, 13'h0, 0);
      vecs[16] = mkv(0, 0,  0, 0,  0, 0, 1, 0, tab_b[5], 0);
      vecs[17] = mkv(1, 0,  1, 9,  0, 1, 0, 0, 13'h0, 0);
      vecs[18] = mkv(1, 0,  1, 9,  1, 0, 1, 1, tab_b[9], 0);
      vecs[19] = mkv(0, 0,  0, 0,  0, 0, 1, 0, tab_b[0], 0);
      vecs[20] = mkv(0, 0,  0, 0,  0, 0, 0, 0, 13'h0, 0);

      // Reset state, with a request pending
      Req0 = 1'b1;
      #12;
      chk("rst_busy", Busy, 0);
      chk("rst_ready", Ready, 0);
      chk("rst_err", Err, 0);
      chk("rst_build_start", Build_start, 0);
      chk("rst_code_start", Code_start, 0);
      chk("rst_gnt0", Gnt0, 0);
      chk("rst_rd_valid", Rd_valid, 0);
      chk("rst_rd_code", Rd_code, 0);
      @(negedge Clk_in);
      n_Rst = 1'b1;
      @(posedge Clk_in); #1;
      @(negedge Clk_in);
      chk("idle_no_gnt", Gnt0, 0);
      Req0 = 1'b0;

      // T1 nominal pass, then T1 lookup, T3 bad symbols, T2 contention
      for (int i = 0; i < NUM_SYM; i++) cur_tab[i] = tab_a[i];
      do_pass(1'b0, 13'h0);
      apply_vecs(0, 14);

      // T5 restart with a grant in the Start cycle, second table
      for (int i = 0; i < NUM_SYM; i++) cur_tab[i] = tab_b[i];
      do_pass(1'b1, tab_a[5]);
      apply_vecs(15, 20);

      // T4 build timeout
      @(posedge Clk_in); #1;
      Start = 1'b1;
      @(posedge Clk_in); #1;
      Start = 1'b0;
      @(negedge Clk_in);
      chk("t4_build_start", Build_start, 1);
      n = 0;
      while (n < 300 && Err !== 1'b1) begin
         @(negedge Clk_in);
         n++;
      end
      chk("t4_timeout_cycles", n, 256);
      chk("t4_err", Err, 1);
      chk("t4_busy_low", Busy, 0);
      chk("t4_ready_low", Ready, 0);
      for (int i = 0; i < NUM_SYM; i++) cur_tab[i] = tab_a[i];
      do_pass(1'b0, 13'h0);
      apply_vecs(0, 1);

      // T6 Start ignored while busy, then reset mid-WAIT
      @(posedge Clk_in); #1;
      Start = 1'b1;
      @(posedge Clk_in); #1;
      Start = 1'b0;
      Build_done = 1'b1;
      @(posedge Clk_in); #1;
      Build_done = 1'b0;
      for (int k = 0; k < 4; k++) @(posedge Clk_in);
      #1;
      Start = 1'b1;
      @(negedge Clk_in);
      chk("t6_busy_wait", Busy, 1);
      @(posedge Clk_in); #1;
      Start = 1'b0;
      @(negedge Clk_in);
      chk("t6_start_ignored", Build_start, 0);
      chk("t6_still_busy", Busy, 1);
      chk("t6_no_code_start", Code_start, 0);
      @(posedge Clk_in); #1;
      n_Rst = 1'b0;
      #1;
      chk("t6_rst_busy", Busy, 0);
      chk("t6_rst_ready", Ready, 0);
      chk("t6_rst_err", Err, 0);
      chk("t6_rst_rd_valid", Rd_valid, 0);
      @(negedge Clk_in);
      n_Rst = 1'b1;
      @(posedge Clk_in); #1;
      @(negedge Clk_in);
      chk("t6_idle_busy", Busy, 0);
      chk("t6_idle_build_start", Build_start, 0);
      @(posedge Clk_in); #1;
      Start = 1'b1;
      @(posedge Clk_in); #1;
      Start = 1'b0;
      @(negedge Clk_in);
      chk("t6_restart_build_start", Build_start, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
